// File: rtl/ecm_pkg.sv
// ecm_pkg: shared constants, header layout and output record for the ECM config decoder.
package ecm_pkg;

    localparam logic [31:0] ecm_control_magic_num = 32'hEC0C_0F1A;

    localparam int WORD_MAGIC  = 0;
    localparam int WORD_SEQ    = 1;
    localparam int WORD_HEADER = 2;
    localparam int WORD_PAD    = 3;

    localparam int MODULE_ID_LSB    = 24;
    localparam int MESSAGE_TYPE_LSB = 16;

    typedef enum logic [2:0] {
        S_MAGIC,
        S_SEQ,
        S_HEADER,
        S_PAD,
        S_PAYLOAD,
        S_DISCARD
    } ecm_state_t;

    typedef struct packed {
        logic        valid;
        logic        first;
        logic        last;
        logic [7:0]  module_id;
        logic [7:0]  message_type;
        logic [7:0]  word_index;
        logic [31:0] data;
    } ecm_config_data_t;

endpackage

// File: rtl/ecm_config_decoder.sv
// ecm_config_decoder: parses framed config messages from a never-stalling stream
// into a registered payload record stream with magic, sequence and length checks.
module ecm_config_decoder
    import ecm_pkg::*;
#(
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int MAX_PAYLOAD_WORDS = 64
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      S_axis_valid,
    input  logic [AXI_DATA_WIDTH-1:0] S_axis_data,
    input  logic                      S_axis_last,
    output logic                      S_axis_ready,
    output logic                      Cfg_valid,
    output logic                      Cfg_first,
    output logic                      Cfg_last,
    output logic [7:0]                Cfg_module_id,
    output logic [7:0]                Cfg_message_type,
    output logic [7:0]                Cfg_word_index,
    output logic [31:0]               Cfg_data,
    output logic                      Err_magic,
    output logic                      Err_seq,
    output logic                      Err_length,
    output logic [15:0]               Msg_count
);

    ecm_state_t       state, state_nxt;
    ecm_config_data_t cfg, cfg_nxt;
    logic             err_magic_nxt, err_seq_nxt, err_length_nxt;
    logic [15:0]      count_nxt;
    logic [7:0]       idx, idx_nxt, mid, mid_nxt, typ, typ_nxt;
    logic [31:0]      exp_seq, exp_seq_nxt;
    logic             first_msg, first_msg_nxt;
    logic             at_max;

    assign S_axis_ready = !Rst;
    assign at_max       = idx == 8'(MAX_PAYLOAD_WORDS - 1);

    always_comb begin
        state_nxt      = state;
        cfg_nxt        = cfg;
        cfg_nxt.valid  = 1'b0;
        cfg_nxt.first  = 1'b0;
        cfg_nxt.last   = 1'b0;
        err_magic_nxt  = 1'b0;
        err_seq_nxt    = 1'b0;
        err_length_nxt = 1'b0;
        count_nxt      = Msg_count;
        idx_nxt        = idx;
        mid_nxt        = mid;
        typ_nxt        = typ;
        exp_seq_nxt    = exp_seq;
        first_msg_nxt  = first_msg;
        if (S_axis_valid) begin
            case (state)
                S_MAGIC: begin
                    if (S_axis_data != ecm_control_magic_num) begin
                        err_magic_nxt = 1'b1;
                        state_nxt     = S_axis_last ? S_MAGIC : S_DISCARD;
                    end else begin
                        err_length_nxt = S_axis_last;
                        state_nxt      = S_axis_last ? S_MAGIC : S_SEQ;
                    end
                end
                S_SEQ: begin
                    // A sequence mismatch is reported but the message still decodes.
                    err_seq_nxt    = !first_msg && (S_axis_data != exp_seq);
                    exp_seq_nxt    = S_axis_data + 32'd1;
                    first_msg_nxt  = 1'b0;
                    err_length_nxt = S_axis_last;
                    state_nxt      = S_axis_last ? S_MAGIC : S_HEADER;
                end
                S_HEADER: begin
                    mid_nxt        = S_axis_data[MODULE_ID_LSB +: 8];
                    typ_nxt        = S_axis_data[MESSAGE_TYPE_LSB +: 8];
                    err_length_nxt = S_axis_last;
                    state_nxt      = S_axis_last ? S_MAGIC : S_PAD;
                end
                S_PAD: begin
                    idx_nxt        = 8'd0;
                    err_length_nxt = S_axis_last;
                    state_nxt      = S_axis_last ? S_MAGIC : S_PAYLOAD;
                end
                S_PAYLOAD: begin
                    cfg_nxt = '{valid: 1'b1, first: idx == 8'd0, last: S_axis_last || at_max,
                                module_id: mid, message_type: typ, word_index: idx, data: S_axis_data};
                    count_nxt      = (S_axis_last || at_max) ? Msg_count + 16'd1 : Msg_count;
                    err_length_nxt = at_max && !S_axis_last;
                    idx_nxt        = idx + 8'd1;
                    state_nxt      = S_axis_last ? S_MAGIC : (at_max ? S_DISCARD : S_PAYLOAD);
                end
                default: state_nxt = S_axis_last ? S_MAGIC : S_DISCARD;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= S_MAGIC;
            cfg        <= '0;
            Err_magic  <= 1'b0;
            Err_seq    <= 1'b0;
            Err_length <= 1'b0;
            Msg_count  <= 16'd0;
            idx        <= 8'd0;
            mid        <= 8'd0;
            typ        <= 8'd0;
            exp_seq    <= 32'd0;
            first_msg  <= 1'b1;
        end else begin
            state      <= state_nxt;
            cfg        <= cfg_nxt;
            Err_magic  <= err_magic_nxt;
            Err_seq    <= err_seq_nxt;
            Err_length <= err_length_nxt;
            Msg_count  <= count_nxt;
            idx        <= idx_nxt;
            mid        <= mid_nxt;
            typ        <= typ_nxt;
            exp_seq    <= exp_seq_nxt;
            first_msg  <= first_msg_nxt;
        end
    end

    assign Cfg_valid        = cfg.valid;
    assign Cfg_first        = cfg.first;
    assign Cfg_last         = cfg.last;
    assign Cfg_module_id    = cfg.module_id;
    assign Cfg_message_type = cfg.message_type;
    assign Cfg_word_index   = cfg.word_index;
    assign Cfg_data         = cfg.data;

endmodule
